mux8_rr_arbiter: RTL and testbench

//  Round-robin scheduler for the shared 8:1 select datapath. Eight requesters compete for one output

---
 rtl/mux8_arb_pkg.sv | 26 ++
 rtl/mux8_rr_arbiter_pick.sv | 40 ++++
 rtl/mux8_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux8_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux8_arb_pkg
//   Shared definitions for the 8-requester round-robin arbiter:
//     N_REQ        number of requesters
//     SEL_W        width of the binary select
//     arb_state_t  arbiter FSM states (IDLE, BUSY)
//     onehot8()    binary index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick8
//   Combinational round-robin pick. It searches req starting at ptr and
//   wraps modulo 8. The first set bit wins.
//   Ports:
//     req  in  [7:0]  request vector
//     ptr  in  [2:0]  highest-priority position for this round
//     any  out        at least one request is pending
//     idx  out [2:0]  index of the winning requester (only meaningful if any)
// ---------------------------------------------------------------------------
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    always_comb begin
        // Rotate so that position ptr lands at bit 0. rot[i] = req[(ptr+i) mod 8].
        dbl = {req, req};
        rot = dbl[ptr +: N_REQ];

        // Priority-encode the lowest set bit of the rotated vector.
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end

        // Un-rotate. The 3-bit add wraps modulo 8 on its own.
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
//   Round-robin scheduler for a shared 8:1 select datapath. It picks a
//   winner among eight requesters and drives the binary select and a one-hot
//   grant. It registers the winner's word and holds it under valid/ready
//   until the consumer accepts it.
//   Parameters:
//     DATA_W     width of each requester word and of out_data
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     req        [7:0]         pending-word flags, one per requester
//     data       [8*DATA_W-1:0] packed requester words, word i at i*DATA_W
//     lock       [7:0]         (ARB_LOCK_EN only) hold priority on the winner
//     ack        [7:0]         one-hot, high during the handshake cycle
//     grant      [7:0]         one-hot channel owner, 0 when idle
//     sel        [2:0]         binary index of the granted requester
//     out_valid                out_data holds a word
//     out_data   [DATA_W-1:0]  registered selected word
//     out_ready                consumer accepts when out_valid & out_ready
//   Configuration:
//     ARB_LOCK_EN  adds the lock port. If lock[winner] is high at handshake,
//                  the winner keeps top priority for the next round.
// ---------------------------------------------------------------------------
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0]        lock,
`endif
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready
);

    arb_state_t        state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [N_REQ-1:0]  grant_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] out_data_nxt;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic              handshake;
    logic              keep_prio;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign handshake = out_valid & out_ready;

    // While BUSY, sel still holds the winner. ack is therefore just the grant,
    // gated by the handshake.
    assign ack = handshake ? grant : '0;

`ifdef ARB_LOCK_EN
    assign keep_prio = lock[sel];
`else
    assign keep_prio = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first. A path that
        // leaves one unassigned would infer a latch.
        state_nxt     = state;
        ptr_nxt       = ptr;
        grant_nxt     = grant;
        sel_nxt       = sel;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt     = BUSY;
                    grant_nxt     = onehot8(pick_idx);
                    sel_nxt       = pick_idx;
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = data[pick_idx*DATA_W +: DATA_W];
                end
            end
            BUSY: begin
                // req is ignored here. The word was already captured at grant.
                if (handshake) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    out_valid_nxt = 1'b0;
                    ptr_nxt       = keep_prio ? sel : sel + SEL_W'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together on the edge, whatever the order of the
    // statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            // NOTE: the data register is reset because out_data is observable
            // and must read 0 after reset. Pure storage arrays would not need it.
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant     <= grant_nxt;
            sel       <= sel_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//   Directed bench for mux8_rr_arbiter with hand-computed expected values.
//   It covers reset, a single requester, the round-robin order, backpressure,
//   async reset mid-transfer and lock (or its absence when ARB_LOCK_EN is
//   undefined).
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          req;
    logic [8*DATA_W-1:0] data;
    logic                out_ready;
    logic [7:0]          lock;
    logic [7:0]          ack;
    logic [7:0]          grant;
    logic [2:0]          sel;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;

    int n_total = 0;
    int n_bad   = 0;

    mux8_rr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Return 1 time unit after the rising edge. Outputs are settled then, and
    // new inputs are applied well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_ack6 [4];
    logic [7:0] lock_tab [4];
    logic [7:0] exp_d;

    initial begin
        req       = 8'($urandom);
        out_ready = 1'b0;
        lock      = 8'h00;
        for (int i = 0; i < 8; i++) data[i*DATA_W +: DATA_W] = 8'h10 + 8'(i);

        // 1. Reset held across edges with random requests.
        #12;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        req   = 8'h00;
        rst_n = 1'b1;
        step();

        // 2. Single requester 4, consumer already ready.
        data[4*DATA_W +: DATA_W] = 8'hA5;
        req       = 8'h10;
        out_ready = 1'b1;
        step();
        check("single_grant", 32'(grant), 32'h10);
        check("single_sel", 32'(sel), 32'h4);
        check("single_data", 32'(out_data), 32'hA5);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_ack", 32'(ack), 32'h10);
        req = 8'h00;
        step();
        check("single_valid_drop", 32'(out_valid), 32'h0);
        check("single_grant_drop", 32'(grant), 32'h0);
        check("single_sel_hold", 32'(sel), 32'h4);
        check("single_data_hold", 32'(out_data), 32'hA5);
        check("single_ack_drop", 32'(ack), 32'h0);
        // After the handshake ptr is 5, so requester 5 beats requester 3.
        req = 8'h28;
        step();
        check("ptr_after_single", 32'(sel), 32'h5);
        step();
        req = 8'h00;
        data[4*DATA_W +: DATA_W] = 8'h14;

        // 3. Round-robin with every requester active, 16 transfers from ptr=0.
        pulse_reset();
        req = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            step();
            exp_d = 8'h10 + 8'(k % 8);
            check("rr_valid_hi", 32'(out_valid), 32'h1);
            check("rr_ack", 32'(ack), 32'(8'h01 << (k % 8)));
            check("rr_data", 32'(out_data), 32'(exp_d));
            step();
            check("rr_valid_lo", 32'(out_valid), 32'h0);
        end

        // 4. Backpressure. ptr wrapped back to 0 after requester 7.
        req       = 8'h03;
        out_ready = 1'b0;
        step();
        check("bp_grant", 32'(grant), 32'h01);
        check("bp_sel", 32'(sel), 32'h0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req = 8'h02;  // requester 0 drops its req while it is granted
            step();
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_sel_hold", 32'(sel), 32'h0);
            check("bp_data_hold", 32'(out_data), 32'h10);
            check("bp_no_ack", 32'(ack), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ack", 32'(ack), 32'h01);
        step();
        check("bp_idle", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        step();
        check("bp_next_grant", 32'(grant), 32'h02);
        check("bp_next_sel", 32'(sel), 32'h1);

        // 5. Async reset between edges while BUSY.
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_grant", 32'(grant), 32'h0);
        check("arst_ack", 32'(ack), 32'h0);
        rst_n = 1'b1;
        req   = 8'h80;
        step();
        check("arst_sel7", 32'(sel), 32'h7);
        check("arst_grant7", 32'(grant), 32'h80);

        // 6. Requesters 1 and 2 compete, with and without lock.
        pulse_reset();
`ifdef ARB_LOCK_EN
        exp_ack6 = '{8'h02, 8'h02, 8'h02, 8'h04};
        lock_tab = '{8'h02, 8'h02, 8'h00, 8'h00};
`else
        exp_ack6 = '{8'h02, 8'h04, 8'h02, 8'h04};
        lock_tab = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
        req       = 8'h06;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lock = lock_tab[k];
            step();
            check("lock_ack", 32'(ack), 32'(exp_ack6[k]));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
